id_ex_pipe: RTL and testbench

ID/EX pipeline register for the 5-stage MIPS core. It sits directly downstream of the main opcode control decoder and the register file. It captures the decoded control bits, operands and register indices into the EX stage. It also detects load-use hazards, inserts bubbles, and honours external hold and flush.

---
 rtl/mips_pkg.sv | 36 +++
 rtl/load_use_detect.sv | 32 +++
 rtl/id_ex_pipe.sv | 168 ++++++++++++++++
 tb/tb_id_ex_pipe.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the 5-stage MIPS core.
//   ALU class encodings, primary opcodes, default datapath widths and the
//   packed control bundle carried through the ID/EX register.
package mips_pkg;

   localparam int unsigned DATA_W_DEFAULT = 32;
   localparam int unsigned REG_AW_DEFAULT = 5;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;

   localparam int unsigned CTRL_W = 10;

   // regDst is not carried: it is folded into the destination index at capture.
   typedef struct packed {
      logic       valid;
      logic       regWr;
      logic       aluSrc;
      logic       br;
      logic       memRe;
      logic       memWr;
      logic       mem2reg;
      logic       jump;
      logic [1:0] aluop;
   } ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: combinational load-use hazard detector.
//   Inputs : ex_valid, ex_memRe, ex_rt   - instruction currently in EX
//            id_valid, id_rs, id_rt      - instruction currently in ID
//            id_regDst, id_br, id_memWr  - decoder bits telling whether ID reads rt
//   Output : hazard - ID consumes the register a load in EX has not yet produced
module load_use_detect
   import mips_pkg::*;
#(
   parameter int unsigned REG_AW = REG_AW_DEFAULT
) (
   input  logic              ex_valid,
   input  logic              ex_memRe,
   input  logic [REG_AW-1:0] ex_rt,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_regDst,
   input  logic              id_br,
   input  logic              id_memWr,
   output logic              hazard
);

   logic id_uses_rt;

   always_comb begin
      // rt is a source for R-type, branch compare and store data
      id_uses_rt = id_regDst | id_br | id_memWr;
      hazard = ex_valid & ex_memRe & (ex_rt != '0) & id_valid &
               ((ex_rt == id_rs) | ((ex_rt == id_rt) & id_uses_rt));
   end

endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register with load-use bubble insertion.
//   clk, rst          : clock, asynchronous active-high reset
//   id_*              : decoded controls, operands and indices from ID
//   hold              : downstream stall, register frozen
//   flush             : taken branch/jump, ID instruction replaced by a bubble
//   ex_*              : registered EX-stage view; ex_wreg is the resolved destination
//   hazard_stall      : combinational, freezes PC and IF/ID during a load-use bubble
//   bubble_cnt/hold_cnt: present only when PIPE_PERF_EN is defined
module id_ex_pipe
   import mips_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEFAULT,
   parameter int unsigned REG_AW = REG_AW_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic              id_regWr,
   input  logic              id_regDst,
   input  logic              id_aluSrc,
   input  logic              id_br,
   input  logic              id_memRe,
   input  logic              id_memWr,
   input  logic              id_mem2reg,
   input  logic              id_jump,
   input  logic [1:0]        id_aluop,
   input  logic [5:0]        id_funct,
   input  logic [DATA_W-1:0] id_pc4,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              hold,
   input  logic              flush,
   output logic              ex_valid,
   output logic              ex_regWr,
   output logic              ex_aluSrc,
   output logic              ex_br,
   output logic              ex_memRe,
   output logic              ex_memWr,
   output logic              ex_mem2reg,
   output logic              ex_jump,
   output logic [1:0]        ex_aluop,
   output logic [5:0]        ex_funct,
   output logic [DATA_W-1:0] ex_pc4,
   output logic [DATA_W-1:0] ex_rs_data,
   output logic [DATA_W-1:0] ex_rt_data,
   output logic [DATA_W-1:0] ex_imm,
   output logic [REG_AW-1:0] ex_rs,
   output logic [REG_AW-1:0] ex_rt,
   output logic [REG_AW-1:0] ex_wreg,
`ifdef PIPE_PERF_EN
   output logic [31:0]       bubble_cnt,
   output logic [31:0]       hold_cnt,
`endif
   output logic              hazard_stall
);

   ctrl_t             ctrl_q;
   ctrl_t             ctrl_load;
   logic [5:0]        funct_q;
   logic [DATA_W-1:0] pc4_q, rs_data_q, rt_data_q, imm_q;
   logic [REG_AW-1:0] rs_q, rt_q, wreg_q;
   logic              hazard;
   logic              bubble;

   load_use_detect #(
      .REG_AW(REG_AW)
   ) u_load_use_detect (
      .ex_valid (ctrl_q.valid),
      .ex_memRe (ctrl_q.memRe),
      .ex_rt    (rt_q),
      .id_valid (id_valid),
      .id_rs    (id_rs),
      .id_rt    (id_rt),
      .id_regDst(id_regDst),
      .id_br    (id_br),
      .id_memWr (id_memWr),
      .hazard   (hazard)
   );

   // hold outranks the hazard bubble; flush outranks both
   assign hazard_stall = hazard & ~flush & ~hold;
   assign bubble       = flush | hazard_stall;

   // Side-effect controls are masked for a non-valid ID slot so it cannot
   // write the register file or memory, or redirect the PC.
   always_comb begin
      ctrl_load         = '0;
      ctrl_load.valid   = id_valid;
      ctrl_load.regWr   = id_valid & id_regWr;
      ctrl_load.aluSrc  = id_aluSrc;
      ctrl_load.br      = id_valid & id_br;
      ctrl_load.memRe   = id_valid & id_memRe;
      ctrl_load.memWr   = id_valid & id_memWr;
      ctrl_load.mem2reg = id_mem2reg;
      ctrl_load.jump    = id_valid & id_jump;
      ctrl_load.aluop   = id_aluop;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q    <= '0;
         funct_q   <= '0;
         pc4_q     <= '0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         wreg_q    <= '0;
      end else if (bubble) begin
         ctrl_q    <= '0;
         funct_q   <= '0;
         pc4_q     <= '0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         wreg_q    <= '0;
      end else if (!hold) begin
         ctrl_q    <= ctrl_load;
         funct_q   <= id_funct;
         pc4_q     <= id_pc4;
         rs_data_q <= id_rs_data;
         rt_data_q <= id_rt_data;
         imm_q     <= id_imm;
         rs_q      <= id_rs;
         rt_q      <= id_rt;
         wreg_q    <= id_regDst ? id_rd : id_rt;
      end
   end

`ifdef PIPE_PERF_EN
   // Only hazard bubbles are counted; flush bubbles are not.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bubble_cnt <= '0;
         hold_cnt   <= '0;
      end else begin
         if (hazard_stall) bubble_cnt <= bubble_cnt + 32'd1;
         if (hold && !flush) hold_cnt <= hold_cnt + 32'd1;
      end
   end
`endif

   assign ex_valid   = ctrl_q.valid;
   assign ex_regWr   = ctrl_q.regWr;
   assign ex_aluSrc  = ctrl_q.aluSrc;
   assign ex_br      = ctrl_q.br;
   assign ex_memRe   = ctrl_q.memRe;
   assign ex_memWr   = ctrl_q.memWr;
   assign ex_mem2reg = ctrl_q.mem2reg;
   assign ex_jump    = ctrl_q.jump;
   assign ex_aluop   = ctrl_q.aluop;
   assign ex_funct   = funct_q;
   assign ex_pc4     = pc4_q;
   assign ex_rs_data = rs_data_q;
   assign ex_rt_data = rt_data_q;
   assign ex_imm     = imm_q;
   assign ex_rs      = rs_q;
   assign ex_rt      = rt_q;
   assign ex_wreg    = wreg_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
`timescale 1ns/1ps
module tb_id_ex_pipe;
   import mips_pkg::*;

   typedef struct packed {
      logic valid, regWr, regDst, aluSrc, br, memRe, memWr, mem2reg, jump;
      logic [1:0]  aluop;
      logic [5:0]  funct;
      logic [31:0] pc4, rs_data, rt_data, imm;
      logic [4:0]  rs, rt, rd;
   } id_t;

   typedef struct packed {
      logic valid, regWr, aluSrc, br, memRe, memWr, mem2reg, jump;
      logic [1:0]  aluop;
      logic [5:0]  funct;
      logic [31:0] pc4, rs_data, rt_data, imm;
      logic [4:0]  rs, rt, wreg;
   } ex_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic hold = 1'b0;
   logic flush = 1'b0;
   id_t  cur = '0;
   ex_t  act;
   ex_t  model = '0;
   ex_t  mon_e;
   ex_t  exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   bubble_m = 0;
   int   hold_m = 0;
   logic last_stall;

   logic        ex_valid, ex_regWr, ex_aluSrc, ex_br, ex_memRe, ex_memWr, ex_mem2reg, ex_jump;
   logic [1:0]  ex_aluop;
   logic [5:0]  ex_funct;
   logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
   logic [4:0]  ex_rs, ex_rt, ex_wreg;
   logic        hazard_stall;
`ifdef PIPE_PERF_EN
   logic [31:0] bubble_cnt, hold_cnt;
`endif

   always #5 clk = ~clk;

   id_ex_pipe dut (
      .clk         (clk),
      .rst         (rst),
      .id_valid    (cur.valid),
      .id_regWr    (cur.regWr),
      .id_regDst   (cur.regDst),
      .id_aluSrc   (cur.aluSrc),
      .id_br       (cur.br),
      .id_memRe    (cur.memRe),
      .id_memWr    (cur.memWr),
      .id_mem2reg  (cur.mem2reg),
      .id_jump     (cur.jump),
      .id_aluop    (cur.aluop),
      .id_funct    (cur.funct),
      .id_pc4      (cur.pc4),
      .id_rs_data  (cur.rs_data),
      .id_rt_data  (cur.rt_data),
      .id_imm      (cur.imm),
      .id_rs       (cur.rs),
      .id_rt       (cur.rt),
      .id_rd       (cur.rd),
      .hold        (hold),
      .flush       (flush),
      .ex_valid    (ex_valid),
      .ex_regWr    (ex_regWr),
      .ex_aluSrc   (ex_aluSrc),
      .ex_br       (ex_br),
      .ex_memRe    (ex_memRe),
      .ex_memWr    (ex_memWr),
      .ex_mem2reg  (ex_mem2reg),
      .ex_jump     (ex_jump),
      .ex_aluop    (ex_aluop),
      .ex_funct    (ex_funct),
      .ex_pc4      (ex_pc4),
      .ex_rs_data  (ex_rs_data),
      .ex_rt_data  (ex_rt_data),
      .ex_imm      (ex_imm),
      .ex_rs       (ex_rs),
      .ex_rt       (ex_rt),
      .ex_wreg     (ex_wreg),
`ifdef PIPE_PERF_EN
      .bubble_cnt  (bubble_cnt),
      .hold_cnt    (hold_cnt),
`endif
      .hazard_stall(hazard_stall)
   );

   always_comb begin
      act         = '0;
      act.valid   = ex_valid;
      act.regWr   = ex_regWr;
      act.aluSrc  = ex_aluSrc;
      act.br      = ex_br;
      act.memRe   = ex_memRe;
      act.memWr   = ex_memWr;
      act.mem2reg = ex_mem2reg;
      act.jump    = ex_jump;
      act.aluop   = ex_aluop;
      act.funct   = ex_funct;
      act.pc4     = ex_pc4;
      act.rs_data = ex_rs_data;
      act.rt_data = ex_rt_data;
      act.imm     = ex_imm;
      act.rs      = ex_rs;
      act.rt      = ex_rt;
      act.wreg    = ex_wreg;
   end

   task automatic chk(input string name, input logic [159:0] got, input logic [159:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   // Reference: a load in EX blocks an ID instruction that reads its rt.
   function automatic logic load_use(ex_t s, id_t i);
      logic reads_rt;
      reads_rt = i.regDst | i.br | i.memWr;
      return s.valid && s.memRe && (s.rt != 5'd0) && i.valid &&
             ((s.rt == i.rs) || ((s.rt == i.rt) && reads_rt));
   endfunction

   function automatic ex_t capture(id_t i);
      ex_t n;
      n.valid   = i.valid;
      n.regWr   = i.valid & i.regWr;
      n.aluSrc  = i.aluSrc;
      n.br      = i.valid & i.br;
      n.memRe   = i.valid & i.memRe;
      n.memWr   = i.valid & i.memWr;
      n.mem2reg = i.mem2reg;
      n.jump    = i.valid & i.jump;
      n.aluop   = i.aluop;
      n.funct   = i.funct;
      n.pc4     = i.pc4;
      n.rs_data = i.rs_data;
      n.rt_data = i.rt_data;
      n.imm     = i.imm;
      n.rs      = i.rs;
      n.rt      = i.rt;
      n.wreg    = i.regDst ? i.rd : i.rt;
      return n;
   endfunction

   function automatic id_t rnd_data();
      id_t i;
      i         = '0;
      i.pc4     = $urandom;
      i.rs_data = $urandom;
      i.rt_data = $urandom;
      i.imm     = $urandom;
      i.rd      = 5'($urandom_range(0, 31));
      return i;
   endfunction

   function automatic id_t mk_lw(logic [4:0] rt, logic [4:0] rs);
      id_t i;
      i = rnd_data();
      i.valid = 1'b1; i.regWr = 1'b1; i.aluSrc = 1'b1; i.memRe = 1'b1; i.mem2reg = 1'b1;
      i.aluop = ALUOP_ADD; i.funct = 6'h23;
      i.rs = rs; i.rt = rt;
      return i;
   endfunction

   function automatic id_t mk_rtype(logic [4:0] rd, logic [4:0] rs, logic [4:0] rt);
      id_t i;
      i = rnd_data();
      i.valid = 1'b1; i.regWr = 1'b1; i.regDst = 1'b1; i.aluop = ALUOP_FUNCT; i.funct = 6'h20;
      i.rs = rs; i.rt = rt; i.rd = rd;
      return i;
   endfunction

   function automatic id_t mk_addi(logic [4:0] rt, logic [4:0] rs);
      id_t i;
      i = rnd_data();
      i.valid = 1'b1; i.regWr = 1'b1; i.aluSrc = 1'b1; i.aluop = ALUOP_ADD; i.imm = 32'd5;
      i.rs = rs; i.rt = rt;
      return i;
   endfunction

   function automatic id_t rnd_instr();
      id_t i;
      i = rnd_data();
      i.valid   = ($urandom_range(0, 9) != 0);
      i.regWr   = 1'($urandom); i.regDst = 1'($urandom); i.aluSrc = 1'($urandom);
      i.br      = 1'($urandom); i.memRe  = 1'($urandom); i.memWr  = 1'($urandom);
      i.mem2reg = 1'($urandom); i.jump   = 1'($urandom);
      i.aluop   = 2'($urandom_range(0, 2));
      i.funct   = 6'($urandom_range(0, 63));
      i.rs      = 5'($urandom_range(0, 3));
      i.rt      = 5'($urandom_range(0, 3));
      i.rd      = 5'($urandom_range(0, 3));
      return i;
   endfunction

   // Drive one cycle of ID inputs, check the stall, push the expected EX state.
   task automatic step(input id_t i, input logic h, input logic f);
      logic lu;
      @(negedge clk);
      cur = i; hold = h; flush = f;
      #1;
      lu = load_use(model, i);
      last_stall = hazard_stall;
      chk("hazard_stall", 160'(hazard_stall), 160'(lu & ~f & ~h));
      if (f) begin
         model = '0;
      end else if (!h) begin
         if (lu) begin
            model = '0;
            bubble_m++;
         end else begin
            model = capture(i);
         end
      end
      if (h && !f) hold_m++;
      exp_q.push_back(model);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (act !== mon_e) begin
               errors++;
               $display("FAIL ex_state: got %h expected %h", act, mon_e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      id_t a;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", 160'(act), 160'(0));
      chk("reset_stall", 160'(hazard_stall), 160'(0));
      @(negedge clk);
      rst = 1'b0;

      // lw $8 then add $9,$8,$10: one bubble, then the add
      step(mk_lw(5'd8, 5'd1), 1'b0, 1'b0);
      a = mk_rtype(5'd9, 5'd8, 5'd10);
      step(a, 1'b0, 1'b0);
      chk("t2_stall", 160'(last_stall), 160'(1));
      step(a, 1'b0, 1'b0);
      chk("t2_no_stall", 160'(last_stall), 160'(0));
      @(posedge clk); #2;
      chk("t2_wreg", 160'(ex_wreg), 160'(9));
      chk("t2_valid", 160'(ex_valid), 160'(1));

      // lw $0 never stalls
      step(mk_lw(5'd0, 5'd1), 1'b0, 1'b0);
      step(mk_rtype(5'd9, 5'd0, 5'd0), 1'b0, 1'b0);
      chk("t3_stall", 160'(last_stall), 160'(0));
      @(posedge clk); #2;
      chk("t3_capture", 160'(ex_valid), 160'(1));

      // rt match without rt use: stall only through rs
      step(mk_lw(5'd8, 5'd1), 1'b0, 1'b0);
      a = mk_addi(5'd8, 5'd8);
      step(a, 1'b0, 1'b0);
      chk("t4_rs_stall", 160'(last_stall), 160'(1));
      step(a, 1'b0, 1'b0);
      chk("t4_after_bubble", 160'(last_stall), 160'(0));
      step(mk_lw(5'd8, 5'd1), 1'b0, 1'b0);
      step(mk_addi(5'd8, 5'd3), 1'b0, 1'b0);
      chk("t4_rt_unused", 160'(last_stall), 160'(0));

      // hold freezes, hold+flush bubbles
      step(mk_lw(5'd8, 5'd1), 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) step(rnd_instr(), 1'b1, 1'b0);
      @(posedge clk); #2;
      chk("t5_hold_valid", 160'(ex_valid), 160'(1));
      chk("t5_hold_rt", 160'(ex_rt), 160'(8));
      step(rnd_instr(), 1'b1, 1'b1);
      @(posedge clk); #2;
      chk("t5_flush_valid", 160'(ex_valid), 160'(0));

      // asynchronous reset mid-cycle while a load-use stall is active
      step(mk_lw(5'd8, 5'd1), 1'b0, 1'b0);
      @(posedge clk); #2;
      cur = mk_rtype(5'd9, 5'd8, 5'd10); hold = 1'b0; flush = 1'b0;
      #1;
      chk("t1_pre_stall", 160'(hazard_stall), 160'(1));
      rst = 1'b1;
      #1;
      chk("t1_rst_outputs", 160'(act), 160'(0));
      chk("t1_rst_stall", 160'(hazard_stall), 160'(0));
`ifdef PIPE_PERF_EN
      chk("t1_rst_bubble_cnt", 160'(bubble_cnt), 160'(0));
      chk("t1_rst_hold_cnt", 160'(hold_cnt), 160'(0));
`endif
      @(negedge clk);
      rst = 1'b0;
      model = '0; bubble_m = 0; hold_m = 0;

      // two load-use pairs, four holds, one flush
      for (int k = 0; k < 2; k++) begin
         step(mk_lw(5'd8, 5'd1), 1'b0, 1'b0);
         a = mk_rtype(5'd9, 5'd8, 5'd10);
         step(a, 1'b0, 1'b0);
         step(a, 1'b0, 1'b0);
      end
      for (int k = 0; k < 4; k++) step(rnd_instr(), 1'b1, 1'b0);
      step(rnd_instr(), 1'b0, 1'b1);
      @(posedge clk); #2;
`ifdef PIPE_PERF_EN
      chk("t6_bubble_cnt", 160'(bubble_cnt), 160'(2));
      chk("t6_hold_cnt", 160'(hold_cnt), 160'(4));
`endif

      for (int k = 0; k < 400; k++)
         step(rnd_instr(), $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);

      repeat (2) @(posedge clk);
      #2;
      chk("queue_drained", 160'(exp_q.size()), 160'(0));
`ifdef PIPE_PERF_EN
      chk("final_bubble_cnt", 160'(bubble_cnt), 160'(bubble_m));
      chk("final_hold_cnt", 160'(hold_cnt), 160'(hold_m));
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
